register_file: RTL
==================

# register_file

Dual-port 16 x 16-bit general register file that executes the enable/write-enable/byte-enable commands issued by the register sequencer. It stores the CPU's working registers and returns operand A and operand B to the ALU and address path. It commits writes on the COMMIT-phase edge under the sequencer's control. The sequencer decides when to act; this block responds and has no phase awareness of its own.

## Interface
- NUM_REGS, 16, number of registers.
- ADDR_WIDTH, 4, register address width (log2 NUM_REGS).
- DATA_WIDTH, 16, register width; must be 16 (two byte lanes).

- CLK  in  1  system clock, all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ARGA  in  ADDR_WIDTH  port A register address.
- ARGB  in  ADDR_WIDTH  port B register address.
- REGA_EN  in  1  port A access enable (read capture and write qualifier).
- REGA_WEN  in  1  port A write enable; effective only with REGA_EN.
- REGA_BYTE_EN  in  2  port A lane enables: 00 NONE, 01 LOW, 10 HIGH, 11 BOTH (`REG_BYTE_ENX_*`).
- REGB_EN  in  1  port B access enable.
- REGB_WEN  in  1  port B write enable; effective only with REGB_EN; always full word.
- DIN_A  in  16  port A write data, lane-aligned.
- DIN_B  in  16  port B write data (pointer update value).
- DOUT_A  out  16  registered port A read data.
- DOUT_B  out  16  registered port B read data.

## Operation
- Storage: NUM_REGS x 16-bit flops, no hardwired register.
- Port A write: on an edge where REGA_EN=1 and REGA_WEN=1, write lanes selected by REGA_BYTE_EN. Bit 0 writes DIN_A[7:0] into [7:0]. Bit 1 writes DIN_A[15:8] into [15:8]. Unselected lanes keep their value. BYTE_EN=NONE means no write.
- Lane alignment: there is no lane swapping. A byte destined for the high lane is presented on DIN_A[15:8].
- Port B write: on an edge where REGB_EN=1 and REGB_WEN=1, write all 16 bits of DIN_B to ARGB.
- WEN with EN=0 is ignored on both ports.
- Simultaneous write, ARGA==ARGB: port A wins on the lanes it enables. Port B supplies the remaining lanes. A BOTH write leaves nothing of B. A LOW write puts B's high byte in [15:8].
- Different addresses: both writes occur on the same edge.
- Read capture: on an edge where REGx_EN=1, DOUT_x loads the full 16-bit pre-edge contents of reg[ARGx]. REGA_BYTE_EN does not gate reads.
- Hold: when REGx_EN=0, DOUT_x holds its value.
- Read-during-write, same edge and same address: DOUT captures the old contents (read-before-write). The new value is visible on the next EN edge.
- Port independence: port A and port B reads are fully independent; there is no arbitration.

## Timing
- Reset: while RESET_N=0, all registers, DOUT_A and DOUT_B are 0x0000, asynchronously. All EN/WEN inputs are ignored.
- Reset release: the first edge with RESET_N=1 may capture or write.
- Reset mid-write: an assertion at any time overrides the pending edge. Storage is 0 afterwards, with no partial write.
- Read latency: 1 cycle. ARGx and EN are sampled at edge N; DOUT_x is valid after edge N.
- Write latency: 0 cycles to storage. Data written at edge N is readable via a capture at edge N+1, so DOUT reflects it after N+1.
- Sequencer cadence: EN is high from DECODE through COMMIT. WEN is high only in COMMIT, so the write lands on the COMMIT→FETCH edge.
- Combinational paths: none from inputs to outputs.

## Test plan
- Reset: preload reg3=0x1234, pulse RESET_N low mid-cycle -> DOUT_A=DOUT_B=0 immediately; a subsequent read of reg3 returns 0x0000.
- Word write/read: A writes 0xBEEF to reg5 with BOTH, then read ARGA=ARGB=5 -> both DOUTs 0xBEEF one cycle after the EN edge. Same-edge read during the write returns the old value.
- Byte lanes: reg2=0x1234. LOW write DIN_A=0xAAFF -> 0x12FF. HIGH write DIN_A=0x55AA -> 0x55FF. NONE with WEN=1 -> unchanged.
- Dual write, different addresses: A BOTH 0x1111 to r1 and B 0x2222 to r4 on one edge -> r1=0x1111, r4=0x2222.
- Collision: ARGA=ARGB=7, A LOW 0x00CC, B 0xAB01 -> r7=0xABCC. A BOTH 0x1234 with B 0xFFFF -> r7=0x1234.
- Gating: WEN=1 with EN=0 -> no write and DOUT holds. EN toggles with ARG changes -> DOUT updates only on EN edges.

Source files
------------

// File: rtl/register_file.sv
// register_file: dual-port NUM_REGS x DATA_WIDTH working register file.
// Commands (enable / write-enable / byte-enable) come from the register
// sequencer; this block has no phase awareness and simply acts on each edge.
//
// Ports:
//   CLK           rising-edge clock
//   RESET_N       async active-low reset; clears storage and both outputs
//   ARGA, ARGB    port A / port B register addresses
//   REGA_EN       port A access enable (read capture, write qualifier)
//   REGA_WEN      port A write enable (needs REGA_EN)
//   REGA_BYTE_EN  port A lane enables: 00 none, 01 low, 10 high, 11 both
//   REGB_EN       port B access enable
//   REGB_WEN      port B full-word write enable (needs REGB_EN)
//   DIN_A, DIN_B  write data; DIN_A is lane-aligned, no byte swapping
//   DOUT_A/B      registered read data, 1-cycle latency, read-before-write
//
// DATA_WIDTH must be 16: the lane logic assumes exactly two byte lanes.
module register_file #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [ADDR_WIDTH-1:0] ARGA,
  input  logic [ADDR_WIDTH-1:0] ARGB,
  input  logic                  REGA_EN,
  input  logic                  REGA_WEN,
  input  logic [1:0]            REGA_BYTE_EN,
  input  logic                  REGB_EN,
  input  logic                  REGB_WEN,
  input  logic [DATA_WIDTH-1:0] DIN_A,
  input  logic [DATA_WIDTH-1:0] DIN_B,
  output logic [DATA_WIDTH-1:0] DOUT_A,
  output logic [DATA_WIDTH-1:0] DOUT_B
);

  localparam int unsigned LANE_W = DATA_WIDTH / 2;

  localparam logic [1:0] REG_BYTE_ENX_NONE = 2'b00;
  localparam logic [1:0] REG_BYTE_ENX_LOW  = 2'b01;
  localparam logic [1:0] REG_BYTE_ENX_HIGH = 2'b10;
  localparam logic [1:0] REG_BYTE_ENX_BOTH = 2'b11;

  logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];

  logic a_wr;
  logic b_wr;
  logic a_lane_lo;
  logic a_lane_hi;

  // Write qualifiers: WEN is meaningless without the matching EN.
  always_comb begin
    a_wr = REGA_EN & REGA_WEN;
    b_wr = REGB_EN & REGB_WEN;
  end

  // Decode port A lane selection.
  always_comb begin
    a_lane_lo = 1'b0;
    a_lane_hi = 1'b0;
    case (REGA_BYTE_EN)
      REG_BYTE_ENX_NONE: begin
        a_lane_lo = 1'b0;
        a_lane_hi = 1'b0;
      end
      REG_BYTE_ENX_LOW: begin
        a_lane_lo = 1'b1;
      end
      REG_BYTE_ENX_HIGH: begin
        a_lane_hi = 1'b1;
      end
      REG_BYTE_ENX_BOTH: begin
        a_lane_lo = 1'b1;
        a_lane_hi = 1'b1;
      end
      default: begin
        a_lane_lo = 1'b0;
        a_lane_hi = 1'b0;
      end
    endcase
  end

  // Next storage value. Port B lays down the full word first, then port A
  // overlays only its enabled lanes, so on an address collision A wins its
  // lanes and B fills whatever A left alone.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_nxt[i] = regs[i];
      if (b_wr && (ARGB == ADDR_WIDTH'(i))) begin
        regs_nxt[i] = DIN_B;
      end
      if (a_wr && (ARGA == ADDR_WIDTH'(i))) begin
        if (a_lane_lo) begin
          regs_nxt[i][LANE_W-1:0] = DIN_A[LANE_W-1:0];
        end
        if (a_lane_hi) begin
          regs_nxt[i][DATA_WIDTH-1:LANE_W] = DIN_A[DATA_WIDTH-1:LANE_W];
        end
      end
    end
  end

  // Storage flops; reset clears every register with no partial write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

  // Port A read capture: samples pre-edge contents (read-before-write).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DOUT_A <= '0;
    end else if (REGA_EN) begin
      DOUT_A <= regs[ARGA];
    end
  end

  // Port B read capture, fully independent of port A.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DOUT_B <= '0;
    end else if (REGB_EN) begin
      DOUT_B <= regs[ARGB];
    end
  end

endmodule
